// File: rtl/pipe_chk_pkg.sv
// Shared lane-state encoding and default constants for the dual-lane stream checker.
package pipe_chk_pkg;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } lane_state_t;

    localparam int DEF_DW   = 32;
    localparam int DEF_STEP = 2;
    localparam int DEF_ECW  = 16;

endpackage

// File: rtl/lane_seq_checker.sv
// Per-lane +STEP sequence tracker: beat/error counters and a combinational mismatch strobe.
//   state | meaning
//   SYNC  | no reference yet; next accepted beat seeds the expected value
//   TRACK | each accepted beat is compared against the expected value
module lane_seq_checker
    import pipe_chk_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int STEP = DEF_STEP,
    parameter int ECW  = DEF_ECW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_stall,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    input  logic          i_flush,
    output logic [31:0]   o_rx_count,
    output logic [ECW-1:0] o_err_count,
    output logic          o_mismatch
);

    localparam logic [DW-1:0] W_STEP = DW'(STEP);

    lane_state_t    r_state;
    lane_state_t    w_state_nxt;
    logic [DW-1:0]  r_exp;
    logic [DW-1:0]  w_exp_nxt;
    logic [31:0]    r_rx;
    logic [31:0]    w_rx_nxt;
    logic [ECW-1:0] r_err;
    logic [ECW-1:0] w_err_nxt;
    logic           w_beat;
    logic           w_mismatch;

    assign w_beat = i_valid & ~i_flush & ~i_stall;

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_rx_nxt    = r_rx;
        w_err_nxt   = r_err;
        w_mismatch  = 1'b0;
        if (i_flush && !i_stall) begin
            w_state_nxt = SYNC;
        end else if (w_beat) begin
            w_rx_nxt    = r_rx + 32'd1;
            w_state_nxt = TRACK;
            if (r_state == TRACK && i_data != r_exp) begin
                w_mismatch = 1'b1;
                w_exp_nxt  = i_data + W_STEP;
                if (r_err != {ECW{1'b1}})
                    w_err_nxt = r_err + ECW'(1);
            end else if (r_state == TRACK) begin
                w_exp_nxt = r_exp + W_STEP;
            end else begin
                w_exp_nxt = i_data + W_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SYNC;
            r_exp   <= '0;
            r_rx    <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_rx    <= w_rx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_rx_count  = r_rx;
    assign o_err_count = r_err;
    assign o_mismatch  = w_mismatch;

endmodule

// File: rtl/pipe_stream_checker.sv
// Dual-lane pipeline tail checker: first-error capture, sticky error flag and
// a free-running periodic stall request source.
module pipe_stream_checker
    import pipe_chk_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int STEP         = DEF_STEP,
    parameter int ECW          = DEF_ECW,
    parameter int STALL_PERIOD = 64,
    parameter int STALL_LEN    = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           global_stall,
    input  logic [DW-1:0]  in_data_1,
    input  logic           in_valid_1,
    input  logic           in_flush_1,
    input  logic [DW-1:0]  in_data_2,
    input  logic           in_valid_2,
    input  logic           in_flush_2,
    output logic           stall_req,
    output logic [31:0]    rx_count_1,
    output logic [31:0]    rx_count_2,
    output logic [ECW-1:0] err_count_1,
    output logic [ECW-1:0] err_count_2,
    output logic           err_flag,
    output logic [DW-1:0]  first_err_data,
    output logic           first_err_lane
);

    logic          w_mm_1;
    logic          w_mm_2;
    logic          r_err_flag;
    logic [DW-1:0] r_first_data;
    logic          r_first_lane;
    logic [31:0]   r_sc;
    logic          r_stall_req;

    lane_seq_checker #(.DW(DW), .STEP(STEP), .ECW(ECW)) u_lane_1 (
        .clk         (clk),
        .rst         (reset),
        .i_stall     (global_stall),
        .i_data      (in_data_1),
        .i_valid     (in_valid_1),
        .i_flush     (in_flush_1),
        .o_rx_count  (rx_count_1),
        .o_err_count (err_count_1),
        .o_mismatch  (w_mm_1)
    );

    lane_seq_checker #(.DW(DW), .STEP(STEP), .ECW(ECW)) u_lane_2 (
        .clk         (clk),
        .rst         (reset),
        .i_stall     (global_stall),
        .i_data      (in_data_2),
        .i_valid     (in_valid_2),
        .i_flush     (in_flush_2),
        .o_rx_count  (rx_count_2),
        .o_err_count (err_count_2),
        .o_mismatch  (w_mm_2)
    );

    // Lane 1 wins a same-cycle tie for the first capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_flag   <= 1'b0;
            r_first_data <= '0;
            r_first_lane <= 1'b0;
        end else if (!r_err_flag && (w_mm_1 || w_mm_2)) begin
            r_err_flag   <= 1'b1;
            r_first_data <= w_mm_1 ? in_data_1 : in_data_2;
            r_first_lane <= ~w_mm_1;
        end
    end

    // Stall source keeps running through global_stall since it feeds that network.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc        <= '0;
            r_stall_req <= 1'b0;
        end else if (STALL_PERIOD == 0) begin
            r_sc        <= '0;
            r_stall_req <= 1'b0;
        end else begin
            r_stall_req <= (r_sc < 32'(STALL_LEN));
            r_sc        <= (r_sc == 32'(STALL_PERIOD - 1)) ? 32'd0 : r_sc + 32'd1;
        end
    end

    assign stall_req      = r_stall_req;
    assign err_flag       = r_err_flag;
    assign first_err_data = r_first_data;
    assign first_err_lane = r_first_lane;

endmodule

// File: tb/tb_pipe_stream_checker.sv
// Bench for pipe_stream_checker: directed scenarios plus randomized traffic against a beat-level model.
module tb_pipe_stream_checker;

    localparam int ECW = 4;
    localparam int SAT = 15;

    logic           clk;
    logic           reset;
    logic           global_stall;
    logic [31:0]    in_data_1, in_data_2;
    logic           in_valid_1, in_valid_2, in_flush_1, in_flush_2;
    logic           stall_req;
    logic [31:0]    rx_count_1, rx_count_2;
    logic [ECW-1:0] err_count_1, err_count_2;
    logic           err_flag;
    logic [31:0]    first_err_data;
    logic           first_err_lane;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_trk [2];
    logic [31:0] m_exp [2];
    logic [31:0] m_rx  [2];
    int          m_err [2];
    bit          m_flag;
    logic [31:0] m_fdata;
    bit          m_flane;
    int          m_cyc;

    pipe_stream_checker #(
        .DW(32), .STEP(2), .ECW(ECW), .STALL_PERIOD(8), .STALL_LEN(3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .global_stall   (global_stall),
        .in_data_1      (in_data_1),
        .in_valid_1     (in_valid_1),
        .in_flush_1     (in_flush_1),
        .in_data_2      (in_data_2),
        .in_valid_2     (in_valid_2),
        .in_flush_2     (in_flush_2),
        .stall_req      (stall_req),
        .rx_count_1     (rx_count_1),
        .rx_count_2     (rx_count_2),
        .err_count_1    (err_count_1),
        .err_count_2    (err_count_2),
        .err_flag       (err_flag),
        .first_err_data (first_err_data),
        .first_err_lane (first_err_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_stall(input int c);
        return (c >= 1) && (((c - 1) % 8) < 3);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_trk[i] = 1'b0;
            m_exp[i] = '0;
            m_rx[i]  = '0;
            m_err[i] = 0;
        end
        m_flag  = 1'b0;
        m_fdata = '0;
        m_flane = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one clock, apply the beat rules to the model.
    task automatic step(input bit v1, input logic [31:0] d1, input bit f1,
                        input bit v2, input logic [31:0] d2, input bit f2, input bit gs);
        logic [31:0] d [2];
        bit v [2];
        bit f [2];
        bit mm [2];
        in_valid_1 = v1; in_data_1 = d1; in_flush_1 = f1;
        in_valid_2 = v2; in_data_2 = d2; in_flush_2 = f2;
        global_stall = gs;
        @(posedge clk);
        d[0] = d1; d[1] = d2; v[0] = v1; v[1] = v2; f[0] = f1; f[1] = f2;
        for (int i = 0; i < 2; i++) begin
            mm[i] = 1'b0;
            if (!gs) begin
                if (f[i]) begin
                    m_trk[i] = 1'b0;
                end else if (v[i]) begin
                    if (m_trk[i] && d[i] !== m_exp[i]) begin
                        mm[i] = 1'b1;
                        if (m_err[i] < SAT) m_err[i]++;
                    end
                    m_exp[i] = d[i] + 32'd2;
                    m_rx[i]  = m_rx[i] + 32'd1;
                    m_trk[i] = 1'b1;
                end
            end
        end
        if (!m_flag && (mm[0] || mm[1])) begin
            m_flag  = 1'b1;
            m_flane = !mm[0];
            m_fdata = mm[0] ? d[0] : d[1];
        end
        m_cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid_1 = 0; in_flush_1 = 0; in_data_1 = '0;
        in_valid_2 = 0; in_flush_2 = 0; in_data_2 = '0;
        global_stall = 0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        m_cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid_1 = 0; in_flush_1 = 0; in_data_1 = '0;
        in_valid_2 = 0; in_flush_2 = 0; in_data_2 = '0;
        global_stall = 0;
        model_clear();
        #12;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall_req got %0h exp 0", stall_req); end
        n_cmp++; if (rx_count_1 !== 32'd0) begin n_bad++; $display("FAIL reset_rx1 got %0h exp 0", rx_count_1); end
        n_cmp++; if (rx_count_2 !== 32'd0) begin n_bad++; $display("FAIL reset_rx2 got %0h exp 0", rx_count_2); end
        n_cmp++; if (err_count_1 !== 4'd0 || err_count_2 !== 4'd0) begin n_bad++; $display("FAIL reset_err got %0h/%0h exp 0/0", err_count_1, err_count_2); end
        n_cmp++; if ({err_flag, first_err_lane} !== 2'b00 || first_err_data !== 32'd0) begin n_bad++; $display("FAIL reset_first_err got %0b%0b %0h exp 0", err_flag, first_err_lane, first_err_data); end
        @(negedge clk);
        reset = 1'b0;
        m_cyc = 0;
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 32'd2, 0, 0, 0, 0, 0);
        step(1, 32'd4, 0, 0, 0, 0, 0);
        step(1, 32'd6, 0, 0, 0, 0, 0);
        step(1, 32'd8, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'd3, 0, 0);
        step(0, 0, 0, 1, 32'd5, 0, 0);
        step(0, 0, 0, 1, 32'd7, 0, 0);
        n_cmp++; if (rx_count_1 !== 32'd4) begin n_bad++; $display("FAIL basic_rx1 got %0d exp 4", rx_count_1); end
        n_cmp++; if (rx_count_2 !== 32'd3) begin n_bad++; $display("FAIL basic_rx2 got %0d exp 3", rx_count_2); end
        n_cmp++; if (err_count_1 !== 4'd0 || err_count_2 !== 4'd0) begin n_bad++; $display("FAIL basic_err got %0d/%0d exp 0/0", err_count_1, err_count_2); end
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL basic_flag got %0b exp 0", err_flag); end
    endtask

    task automatic test_mismatch();
        do_reset();
        step(1, 32'd10, 0, 0, 0, 0, 0);
        step(1, 32'd12, 0, 0, 0, 0, 0);
        step(1, 32'd16, 0, 0, 0, 0, 0);
        n_cmp++; if (err_flag !== 1'b1) begin n_bad++; $display("FAIL mm_flag_latency got %0b exp 1", err_flag); end
        step(1, 32'd18, 0, 0, 0, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd1) begin n_bad++; $display("FAIL mm_err1 got %0d exp 1", err_count_1); end
        n_cmp++; if (first_err_data !== 32'd16) begin n_bad++; $display("FAIL mm_fdata got %0d exp 16", first_err_data); end
        n_cmp++; if (first_err_lane !== 1'b0) begin n_bad++; $display("FAIL mm_flane got %0b exp 0", first_err_lane); end
        n_cmp++; if (rx_count_1 !== 32'd4) begin n_bad++; $display("FAIL mm_rx1 got %0d exp 4", rx_count_1); end
    endtask

    task automatic test_flush();
        do_reset();
        step(1, 32'd100, 0, 0, 0, 0, 0);
        step(1, 32'd102, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 32'd512, 0, 0, 0, 0, 0);
        step(1, 32'd514, 0, 0, 0, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd0) begin n_bad++; $display("FAIL flush_err1 got %0d exp 0", err_count_1); end
        n_cmp++; if (rx_count_1 !== 32'd4) begin n_bad++; $display("FAIL flush_rx1 got %0d exp 4", rx_count_1); end
        step(1, 32'd7, 1, 0, 0, 0, 0);
        n_cmp++; if (rx_count_1 !== 32'd4) begin n_bad++; $display("FAIL flush_valid_dropped got %0d exp 4", rx_count_1); end
        step(1, 32'd9, 0, 0, 0, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd0 || rx_count_1 !== 32'd5) begin n_bad++; $display("FAIL flush_resync got err %0d rx %0d exp 0 5", err_count_1, rx_count_1); end
    endtask

    task automatic test_dual_first();
        do_reset();
        step(1, 32'd20, 0, 1, 32'd30, 0, 0);
        step(1, 32'd99, 0, 1, 32'd77, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd1 || err_count_2 !== 4'd1) begin n_bad++; $display("FAIL dual_err got %0d/%0d exp 1/1", err_count_1, err_count_2); end
        n_cmp++; if (first_err_lane !== 1'b0) begin n_bad++; $display("FAIL dual_flane got %0b exp 0", first_err_lane); end
        n_cmp++; if (first_err_data !== 32'd99) begin n_bad++; $display("FAIL dual_fdata got %0d exp 99", first_err_data); end
        step(0, 0, 0, 1, 32'd5, 0, 0);
        n_cmp++; if (err_count_2 !== 4'd2 || first_err_data !== 32'd99 || first_err_lane !== 1'b0) begin n_bad++; $display("FAIL dual_no_overwrite got %0d %0d %0b exp 2 99 0", err_count_2, first_err_data, first_err_lane); end
    endtask

    task automatic test_stall_and_wrap();
        do_reset();
        step(1, 32'd50, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, $urandom, 1'($urandom_range(0, 1)), 1, $urandom, 1'($urandom_range(0, 1)), 1);
        n_cmp++; if (rx_count_1 !== 32'd1 || rx_count_2 !== 32'd0) begin n_bad++; $display("FAIL gstall_rx got %0d/%0d exp 1/0", rx_count_1, rx_count_2); end
        n_cmp++; if (err_count_1 !== 4'd0 || err_flag !== 1'b0) begin n_bad++; $display("FAIL gstall_err got %0d %0b exp 0 0", err_count_1, err_flag); end
        step(1, 32'd52, 0, 0, 0, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd0 || rx_count_1 !== 32'd2) begin n_bad++; $display("FAIL gstall_resume got err %0d rx %0d exp 0 2", err_count_1, rx_count_1); end
        step(0, 0, 1, 0, 0, 1, 0);
        step(1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFE, 0, 0);
        step(1, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 0);
        n_cmp++; if (err_count_1 !== 4'd0 || err_count_2 !== 4'd0 || err_flag !== 1'b0) begin n_bad++; $display("FAIL wrap_err got %0d/%0d %0b exp 0/0 0", err_count_1, err_count_2, err_flag); end
        n_cmp++; if (rx_count_1 !== 32'd5 || rx_count_2 !== 32'd3) begin n_bad++; $display("FAIL wrap_rx got %0d/%0d exp 5/3", rx_count_1, rx_count_2); end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1, 32'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(1, 32'd0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_count_1 !== 4'(SAT)) begin n_bad++; $display("FAIL sat_err1 got %0d exp %0d", err_count_1, SAT); end
        n_cmp++; if (rx_count_1 !== 32'd21) begin n_bad++; $display("FAIL sat_rx1 got %0d exp 21", rx_count_1); end
    endtask

    task automatic test_stall_gen();
        do_reset();
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL sgen_c0 got %0b exp 0", stall_req); end
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 0, 0, 0, 0, (i % 4) == 1);
            n_cmp++; if (stall_req !== exp_stall(m_cyc)) begin n_bad++; $display("FAIL sgen_c%0d got %0b exp %0b", m_cyc, stall_req, exp_stall(m_cyc)); end
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL sgen_async_reset got %0b exp 0", stall_req); end
        n_cmp++; if (rx_count_1 !== 32'd0 || err_flag !== 1'b0) begin n_bad++; $display("FAIL sgen_async_clear got rx %0d flag %0b exp 0 0", rx_count_1, err_flag); end
        do_reset();
    endtask

    task automatic test_random();
        bit          v [2];
        bit          f [2];
        logic [31:0] d [2];
        bit          gs;
        do_reset();
        step(1, 32'hFFFF_FFF0, 0, 1, 32'h7FFF_FFF8, 0, 0);
        for (int n = 0; n < 400; n++) begin
            gs = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 2; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                f[i] = ($urandom_range(0, 14) == 0);
                d[i] = ($urandom_range(0, 5) == 0) ? 32'($urandom) : m_exp[i];
            end
            step(v[0], d[0], f[0], v[1], d[1], f[1], gs);
            n_cmp++; if (rx_count_1 !== m_rx[0]) begin n_bad++; $display("FAIL rnd_rx1 c%0d got %0d exp %0d", n, rx_count_1, m_rx[0]); end
            n_cmp++; if (rx_count_2 !== m_rx[1]) begin n_bad++; $display("FAIL rnd_rx2 c%0d got %0d exp %0d", n, rx_count_2, m_rx[1]); end
            n_cmp++; if (err_count_1 !== 4'(m_err[0])) begin n_bad++; $display("FAIL rnd_err1 c%0d got %0d exp %0d", n, err_count_1, m_err[0]); end
            n_cmp++; if (err_count_2 !== 4'(m_err[1])) begin n_bad++; $display("FAIL rnd_err2 c%0d got %0d exp %0d", n, err_count_2, m_err[1]); end
            n_cmp++; if (err_flag !== m_flag) begin n_bad++; $display("FAIL rnd_flag c%0d got %0b exp %0b", n, err_flag, m_flag); end
            n_cmp++; if (first_err_data !== m_fdata || first_err_lane !== m_flane) begin n_bad++; $display("FAIL rnd_first c%0d got %0h/%0b exp %0h/%0b", n, first_err_data, first_err_lane, m_fdata, m_flane); end
            n_cmp++; if (stall_req !== exp_stall(m_cyc)) begin n_bad++; $display("FAIL rnd_stall_req c%0d got %0b exp %0b", m_cyc, stall_req, exp_stall(m_cyc)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_flush();
        test_dual_first();
        test_stall_and_wrap();
        test_saturation();
        test_stall_gen();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
